// File: rtl/dcache_assoc.sv
// Set-associative write-through, no-write-allocate data cache shared by several LSUs
// through a round-robin arbiter, with whole-cache flush and saturating hit/miss counters.
module dcache_assoc #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    controller_read_valid,
  output logic [ADDR_BITS-1:0]                    controller_read_address,
  input  logic                                    controller_read_ready,
  input  logic [DATA_BITS-1:0]                    controller_read_data,
  output logic                                    controller_write_valid,
  output logic [ADDR_BITS-1:0]                    controller_write_address,
  output logic [DATA_BITS-1:0]                    controller_write_data,
  input  logic                                    controller_write_ready,
  input  logic                                    flush,
  output logic                                    flush_busy,
  output logic [CNT_BITS-1:0]                     hit_count,
  output logic [CNT_BITS-1:0]                     miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_BITS - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int CID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOOKUP, S_MEM_READ, S_MEM_WRITE, S_RESPOND, S_RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [CID_W-1:0]     rr_ptr;
  logic                 flush_pend;
  logic [CNT_BITS-1:0]  hit_cnt, miss_cnt;
  logic [NUM_CONSUMERS-1:0]                rd_ready_q, wr_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [WAY_W-1:0]     vptr    [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [CID_W-1:0]     cid;
  logic                 op_write;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic                 gnt_found, gnt_read;
  logic [CID_W-1:0]     gnt_id;
  logic [IDX_W-1:0]     sidx;
  logic [TAG_W-1:0]     stag;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way, fill_way;
  logic [DATA_BITS-1:0] hit_data;
  logic                 has_inv;
  logic                 take_grant;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WAY_W-1:0] way_inc(input logic [WAY_W-1:0] w);
    return (w == WAY_W'(NUM_WAYS - 1)) ? '0 : w + 1'b1;
  endfunction

  // Round-robin grant: first requester at or after rr_ptr.
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_read  = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      c = (int'(rr_ptr) + i) % NUM_CONSUMERS;
      if (!gnt_found && (consumer_read_valid[c] || consumer_write_valid[c])) begin
        gnt_found = 1'b1;
        gnt_read  = consumer_read_valid[c];
        gnt_id    = CID_W'(c);
      end
    end
  end

  assign take_grant = (state == S_IDLE) && !flush_pend && gnt_found;
  assign sidx = addr_q[IDX_W-1:0];
  assign stag = addr_q[ADDR_BITS-1:IDX_W];

  // Tag match across the set, plus fill-way choice: lowest invalid way, else the victim pointer.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    has_inv  = 1'b0;
    fill_way = vptr[sidx];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[sidx][w] && (tag_q[sidx][w] == stag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = data_q[sidx][w];
      end
      if (!has_inv && !valid_q[sidx][w]) begin
        has_inv  = 1'b1;
        fill_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (flush_pend) state_nxt = S_FLUSH;
                   else if (gnt_found) state_nxt = S_LOOKUP;
      S_FLUSH:     state_nxt = S_IDLE;
      S_LOOKUP:    if (op_write) state_nxt = S_MEM_WRITE;
                   else if (hit) state_nxt = S_RESPOND;
                   else state_nxt = S_MEM_READ;
      S_MEM_READ:  if (controller_read_ready) state_nxt = S_RESPOND;
      S_MEM_WRITE: if (controller_write_ready) state_nxt = S_RESPOND;
      S_RESPOND:   state_nxt = S_RELEASE;
      S_RELEASE:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Control state, valid bits, victim pointers, counters and response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        vptr[s]    <= '0;
      end
    end else begin
      state <= state_nxt;
      if (flush) flush_pend <= 1'b1;
      else if (state == S_FLUSH) flush_pend <= 1'b0;
      if (take_grant)
        rr_ptr <= (gnt_id == CID_W'(NUM_CONSUMERS - 1)) ? '0 : gnt_id + 1'b1;
      if (state == S_FLUSH)
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      if (state == S_LOOKUP) begin
        if (hit) hit_cnt <= sat_inc(hit_cnt);
        else     miss_cnt <= sat_inc(miss_cnt);
      end
      if (state == S_MEM_READ && controller_read_ready) begin
        valid_q[sidx][fill_way] <= 1'b1;
        vptr[sidx]              <= way_inc(fill_way);
      end
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      if (state == S_RESPOND) begin
        if (op_write) wr_ready_q[cid] <= 1'b1;
        else begin
          rd_ready_q[cid] <= 1'b1;
          rd_data_q[cid]  <= rdata_q;
        end
      end
    end
  end

  // Request latch and tag/data arrays.
  always_ff @(posedge clk) begin
    if (take_grant) begin
      cid      <= gnt_id;
      op_write <= !gnt_read;
      addr_q   <= gnt_read ? consumer_read_address[gnt_id] : consumer_write_address[gnt_id];
      wdata_q  <= consumer_write_data[gnt_id];
    end
    if (state == S_LOOKUP && hit) begin
      if (op_write) data_q[sidx][hit_way] <= wdata_q;
      else          rdata_q <= hit_data;
    end
    if (state == S_MEM_READ && controller_read_ready) begin
      tag_q[sidx][fill_way]  <= stag;
      data_q[sidx][fill_way] <= controller_read_data;
      rdata_q                <= controller_read_data;
    end
  end

  assign controller_read_valid    = (state == S_MEM_READ);
  assign controller_read_address  = controller_read_valid ? addr_q : '0;
  assign controller_write_valid   = (state == S_MEM_WRITE);
  assign controller_write_address = controller_write_valid ? addr_q : '0;
  assign controller_write_data    = controller_write_valid ? wdata_q : '0;
  assign consumer_read_ready      = rd_ready_q;
  assign consumer_read_data       = rd_data_q;
  assign consumer_write_ready     = wr_ready_q;
  assign flush_busy               = flush_pend;
  assign hit_count                = hit_cnt;
  assign miss_count               = miss_cnt;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: behavioural memory with fixed latency and an optional stall,
// linear sequence of consumer transactions checked with immediate assertions.
module tb_dcache_assoc;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       rv, wv;
  logic [3:0][7:0]  ra, wa, wd;
  logic [3:0]       consumer_read_ready, consumer_write_ready;
  logic [3:0][7:0]  consumer_read_data;
  logic             controller_read_valid, controller_write_valid;
  logic [7:0]       controller_read_address, controller_write_address, controller_write_data;
  logic             c_rd_rdy, c_wr_rdy;
  logic [7:0]       c_rd_data;
  logic             flush, flush_busy;
  logic [15:0]      hit_count, miss_count;

  logic [7:0] mem [256];
  logic       mem_stall;
  int         lat, n_rd, n_wr, both_hi;
  logic [7:0] last_rd_addr, last_wr_addr, last_wr_data;
  int         ntests = 0, nfail = 0;

  dcache_assoc dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(consumer_write_ready),
    .controller_read_valid(controller_read_valid), .controller_read_address(controller_read_address),
    .controller_read_ready(c_rd_rdy), .controller_read_data(c_rd_data),
    .controller_write_valid(controller_write_valid), .controller_write_address(controller_write_address),
    .controller_write_data(controller_write_data), .controller_write_ready(c_wr_rdy),
    .flush(flush), .flush_busy(flush_busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory model: answers each controller request after two valid cycles unless stalled.
  always @(negedge clk) begin
    if (reset) begin
      c_rd_rdy = 1'b0; c_wr_rdy = 1'b0; lat = 0;
    end else begin
      if (controller_read_valid && controller_write_valid) both_hi++;
      if (c_rd_rdy || c_wr_rdy) begin
        c_rd_rdy = 1'b0; c_wr_rdy = 1'b0;
      end else if ((controller_read_valid || controller_write_valid) && !mem_stall) begin
        if (lat >= 1) begin
          lat = 0;
          if (controller_read_valid) begin
            c_rd_rdy = 1'b1; c_rd_data = mem[controller_read_address];
            last_rd_addr = controller_read_address; n_rd++;
          end else begin
            c_wr_rdy = 1'b1; mem[controller_write_address] = controller_write_data;
            last_wr_addr = controller_write_address; last_wr_data = controller_write_data; n_wr++;
          end
        end else lat++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int c, input logic [7:0] a, output logic [7:0] d, output int cyc);
    rv[c] = 1'b1; ra[c] = a; d = '0; cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (consumer_read_ready[c]) begin d = consumer_read_data[c]; cyc = k; break; end
    end
    rv[c] = 1'b0;
    check("read_done", 32'(cyc > 0), 1);
    tick();
    check("read_pulse_one_cycle", 32'(consumer_read_ready), 0);
  endtask

  task automatic do_write(input int c, input logic [7:0] a, input logic [7:0] d);
    int cyc;
    wv[c] = 1'b1; wa[c] = a; wd[c] = d; cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (consumer_write_ready[c]) begin cyc = k; break; end
    end
    wv[c] = 1'b0;
    check("write_done", 32'(cyc > 0), 1);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  logic [7:0] d;
  int         cyc, rd0, wr0, n, ok;
  int         order [4];
  logic [7:0] exp_d [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h15] = 8'hA7;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0; flush = 1'b0; mem_stall = 1'b0;
    n_rd = 0; n_wr = 0; both_hi = 0; last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    reset = 1'b1;
    tick(); tick();
    check("rst_read_ready", 32'(consumer_read_ready), 0);
    check("rst_ctl_read_valid", 32'(controller_read_valid), 0);
    check("rst_hit_count", 32'(hit_count), 0);
    check("rst_miss_count", 32'(miss_count), 0);
    check("rst_flush_busy", 32'(flush_busy), 0);
    reset = 1'b0; tick();

    // Miss then hit on 0x15.
    do_read(0, 8'h15, d, cyc);
    check("miss_data", 32'(d), 32'hA7);
    check("miss_ctl_addr", 32'(last_rd_addr), 32'h15);
    check("miss_ctl_reads", 32'(n_rd), 1);
    check("miss_count_1", 32'(miss_count), 1);
    do_read(0, 8'h15, d, cyc);
    check("hit_data", 32'(d), 32'hA7);
    check("hit_latency", 32'(cyc), 3);
    check("hit_no_ctl", 32'(n_rd), 1);
    check("hit_count_1", 32'(hit_count), 1);

    // Arbitration from rr pointer 0.
    pulse_reset();
    ra[0] = 8'h15; ra[1] = 8'h16; ra[2] = 8'h17; ra[3] = 8'h18;
    for (int i = 0; i < 4; i++) exp_d[i] = mem[ra[i]];
    rv = 4'hF; n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      tick();
      for (int i = 0; i < 4; i++) if (consumer_read_ready[i]) begin
        order[n] = i; check("arb_data", 32'(consumer_read_data[i]), 32'(exp_d[i]));
        rv[i] = 1'b0; n++;
      end
    end
    check("arb_count", n, 4);
    for (int i = 0; i < 4; i++) check("arb_order4", order[i], i);
    rv = 4'b1010; n = 0;
    for (int k = 0; k < 200 && n < 2; k++) begin
      tick();
      for (int i = 0; i < 4; i++) if (consumer_read_ready[i]) begin
        order[n] = i; rv[i] = 1'b0; n++;
      end
    end
    check("arb2_count", n, 2);
    check("arb2_first", order[0], 1);
    check("arb2_second", order[1], 3);
    check("arb_hits", 32'(hit_count), 2);
    check("arb_misses", 32'(miss_count), 4);

    // Write-through hit, then no-allocate write miss.
    wr0 = n_wr; rd0 = n_rd;
    do_write(2, 8'h15, 8'h5C);
    check("wr_ctl_count", n_wr - wr0, 1);
    check("wr_ctl_addr", 32'(last_wr_addr), 32'h15);
    check("wr_ctl_data", 32'(last_wr_data), 32'h5C);
    check("wr_hit_count", 32'(hit_count), 3);
    do_read(2, 8'h15, d, cyc);
    check("wr_line_updated", 32'(d), 32'h5C);
    check("wr_read_no_ctl", n_rd - rd0, 0);
    do_write(1, 8'h22, 8'h3E);
    check("wr_miss_count", 32'(miss_count), 5);
    do_read(1, 8'h22, d, cyc);
    check("noalloc_read_miss", n_rd - rd0, 1);
    check("noalloc_data", 32'(d), 32'h3E);

    // Victim selection in set 1.
    pulse_reset();
    rd0 = n_rd;
    do_read(0, 8'h01, d, cyc);
    do_read(0, 8'h05, d, cyc);
    do_read(0, 8'h09, d, cyc);
    check("fill3_misses", n_rd - rd0, 3);
    do_read(0, 8'h05, d, cyc);
    check("keep_05", n_rd - rd0, 3);
    do_read(0, 8'h01, d, cyc);
    check("evicted_01", n_rd - rd0, 4);
    check("evicted_01_data", 32'(d), 32'(mem[8'h01]));
    do_read(0, 8'h09, d, cyc);
    check("keep_09", n_rd - rd0, 4);
    do_read(0, 8'h05, d, cyc);
    check("evicted_05", n_rd - rd0, 5);

    // Flush raised while a miss is stalled at the controller.
    do_read(0, 8'h15, d, cyc);
    mem_stall = 1'b1; rv[0] = 1'b1; ra[0] = 8'h33; ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin tick(); if (controller_read_valid) ok = 1; end
    check("fl_stall_seen", ok, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_busy_rise", 32'(flush_busy), 1);
    tick(); tick(); tick();
    check("fl_miss_still_open", 32'(controller_read_valid), 1);
    check("fl_busy_held", 32'(flush_busy), 1);
    mem_stall = 1'b0; ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (consumer_read_ready[0]) begin ok = 1; d = consumer_read_data[0]; end
    end
    rv[0] = 1'b0;
    check("fl_miss_done", ok, 1);
    check("fl_miss_data", 32'(d), 32'(mem[8'h33]));
    check("fl_busy_at_done", 32'(flush_busy), 1);
    tick(); tick();
    check("fl_busy_before_flush", 32'(flush_busy), 1);
    tick();
    check("fl_busy_clear", 32'(flush_busy), 0);
    rd0 = n_rd;
    do_read(0, 8'h15, d, cyc);
    check("fl_read_misses", n_rd - rd0, 1);

    // Reset while a controller read is outstanding.
    mem_stall = 1'b1; rv[0] = 1'b1; ra[0] = 8'h44; ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin tick(); if (controller_read_valid) ok = 1; end
    check("rs_stall_seen", ok, 1);
    reset = 1'b1; rv[0] = 1'b0; tick();
    check("rs_ctl_valid", 32'(controller_read_valid), 0);
    check("rs_ctl_addr", 32'(controller_read_address), 0);
    check("rs_hits", 32'(hit_count), 0);
    check("rs_misses", 32'(miss_count), 0);
    check("rs_read_data", 32'(consumer_read_data), 0);
    reset = 1'b0; mem_stall = 1'b0; tick();
    rd0 = n_rd;
    do_read(0, 8'h15, d, cyc);
    check("rs_read_misses", n_rd - rd0, 1);
    check("rs_miss_count", 32'(miss_count), 1);
    check("rs_read_data_ok", 32'(d), 32'h5C);

    check("never_both_valids", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
